// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, state
// encodings and datapath mux select values.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } ctrlState_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_ctrl_output_decode.sv
// Moore output decoder: maps the current FSM state to datapath controls.
// mem_ready only gates the one-shot loads and the store completion pulse.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 2,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic               rst,
  input  ctrlState_t         state,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done
);

  logic memGo;
  assign memGo = (MEM_WAIT_EN == 0) || mem_ready;

  // Per-state control decode; everything is held low while in reset.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_W'(ALUOP_ADD);
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = memGo;
          pc_write  = memGo;
          alu_src_b = SRCB_FOUR;
        end
        S_DECODE:   alu_src_b = SRCB_IMMSH;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = memGo;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_W'(ALUOP_FUNCT);
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_W'(ALUOP_SUB);
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end else begin
      instr_done = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// sticky illegal-opcode flag; outputs come from ctrl_output_decode.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int ALUOP_W     = 2,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state
);

  ctrlState_t stateReg;
  logic       illegalReg;
  logic       memGo;

  assign memGo      = (MEM_WAIT_EN == 0) || mem_ready;
  assign state      = stateReg;
  assign illegal_op = illegalReg;

  // State sequencing; memory states hold until the access completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= S_FETCH;
      illegalReg <= 1'b0;
    end else begin
      case (stateReg)
        S_FETCH:  stateReg <= memGo ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_W'(OP_RTYPE): stateReg <= S_EXEC;
            OP_W'(OP_LW),
            OP_W'(OP_SW):    stateReg <= S_MEM_ADDR;
            OP_W'(OP_BEQ):   stateReg <= S_BRANCH;
            OP_W'(OP_ADDI):  stateReg <= S_ADDI_EX;
            OP_W'(OP_J):     stateReg <= S_JUMP;
            default: begin
              stateReg   <= S_FETCH;
              illegalReg <= 1'b1;
            end
          endcase
        end
        // Only lw and sw reach MEM_ADDR, so anything not lw is a store.
        S_MEM_ADDR: stateReg <= (opcode == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   stateReg <= memGo ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:   stateReg <= memGo ? S_FETCH : S_MEM_WR;
        S_EXEC:     stateReg <= S_R_WB;
        S_ADDI_EX:  stateReg <= S_ADDI_WB;
        S_MEM_WB,
        S_R_WB,
        S_BRANCH,
        S_ADDI_WB,
        S_JUMP:     stateReg <= S_FETCH;
        default:    stateReg <= S_FETCH;
      endcase
    end
  end

  ctrl_output_decode #(
    .ALUOP_W     (ALUOP_W),
    .MEM_WAIT_EN (MEM_WAIT_EN)
  ) uDecode (
    .rst           (rst),
    .state         (stateReg),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done)
  );

endmodule
